// File: rtl/uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_engine                                                |
// | Desc     : Mid-bit sampling UART receiver with parity/stop checking and  |
// |            a ready/clear handshake. Define RX_SYNC_EN to add a 2-flop    |
// |            input synchronizer for external pins.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_engine #(
    parameter int KW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [KW-1:0] K,
    input  logic          EIGHT,
    input  logic          PEN,
    input  logic          OHEL,
    input  logic          RX_in,
    input  logic          CLR_RDY,
    output logic          RXRDY,
    output logic [7:0]    DATA,
    output logic          PERR,
    output logic          FERR,
    output logic          OVF
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    logic w_rx;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], RX_in};
    end
    assign w_rx = sync_q[1];
`else
    assign w_rx = RX_in;
`endif

    state_t        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    sr_q, sr_d;
    logic          eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic          rxrdy_q, perr_q, ferr_q, ovf_q;
    logic [7:0]    data_q;

    logic          w_done;
    logic [3:0]    w_nbits;
    logic [3:0]    w_shift;
    logic [8:0]    w_aligned;
    logic [7:0]    w_data;
    logic          w_par;
    logic          w_perr;
    logic          w_ferr;

    // Frame geometry comes from the configuration latched at start confirm
    assign w_nbits   = 4'd9 + {3'b000, eight_q} + {3'b000, pen_q};
    assign w_shift   = 4'd11 - w_nbits;
    assign w_aligned = 9'(sr_q >> w_shift);
    assign w_data    = eight_q ? w_aligned[7:0] : {1'b0, w_aligned[6:0]};
    assign w_par     = eight_q ? w_aligned[8] : w_aligned[7];
    assign w_perr    = pen_q & ((^w_data ^ w_par) != ohel_q);
    assign w_ferr    = ~sr_q[9];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        w_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!w_rx) state_d = S_START;
            end
            S_START: begin
                cnt_d = cnt_q + KW'(1);
                if (cnt_q == (K >> 1) - KW'(1)) begin
                    cnt_d = '0;
                    if (w_rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 4'd1;
                        sr_d    = '0;
                        eight_d = EIGHT;
                        pen_d   = PEN;
                        ohel_d  = OHEL;
                    end
                end
            end
            S_DATA: begin
                if (bit_q == w_nbits) begin
                    w_done  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + KW'(1);
                    // Counter restarts at every sample so timing never drifts
                    if (cnt_q == K - KW'(1)) begin
                        cnt_d = '0;
                        sr_d  = {w_rx, sr_q[9:1]};
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxrdy_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (w_done) begin
            data_q  <= w_data;
            perr_q  <= w_perr;
            ferr_q  <= w_ferr;
            rxrdy_q <= 1'b1;
            // A simultaneous clear wins over the overflow this frame would raise
            ovf_q   <= CLR_RDY ? 1'b0 : (ovf_q | rxrdy_q);
        end else if (CLR_RDY) begin
            rxrdy_q <= 1'b0;
            ovf_q   <= 1'b0;
        end
    end

    assign RXRDY = rxrdy_q;
    assign DATA  = data_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;
    assign OVF   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_engine                                             |
// | Desc     : Scoreboard bench for uart_rx_engine (honours RX_SYNC_EN).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx_engine;

    logic        clk;
    logic        reset;
    logic [19:0] K;
    logic        EIGHT, PEN, OHEL, RX_in, CLR_RDY;
    logic        RXRDY, PERR, FERR, OVF;
    logic [7:0]  DATA;

    uart_rx_engine #(.KW(20)) dut (
        .clk(clk), .reset(reset), .K(K), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
        .RX_in(RX_in), .CLR_RDY(CLR_RDY), .RXRDY(RXRDY), .DATA(DATA),
        .PERR(PERR), .FERR(FERR), .OVF(OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   kc       = 16;
    logic       m_rdy, m_ovf, m_perr, m_ferr;
    logic [7:0] m_data;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_rdy"},  int'(RXRDY), int'(m_rdy));
        check({tag, "_data"}, int'(DATA),  int'(m_data));
        check({tag, "_perr"}, int'(PERR),  int'(m_perr));
        check({tag, "_ferr"}, int'(FERR),  int'(m_ferr));
        check({tag, "_ovf"},  int'(OVF),   int'(m_ovf));
    endtask

    task automatic clear_rdy();
        CLR_RDY = 1'b1;
        wait_clks(1);
        CLR_RDY = 1'b0;
        m_rdy = 1'b0;
        m_ovf = 1'b0;
        check_outputs("clr");
    endtask

    // Drives one frame; checks at the exact cycle RXRDY/outputs must update
    task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic pflip, input logic stopv,
                              input logic clr_dn);
        logic [10:0] bits;
        int          nb;
        int          lat;
        exp_t        ex;
        exp_t        got;
        bits = '1;
        nb   = 0;
        EIGHT = e; PEN = p; OHEL = o;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 7 + int'(e); i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (p) begin
            bits[nb] = (e ? ^d : ^d[6:0]) ^ o ^ pflip; nb++;
        end
        bits[nb] = stopv; nb++;
        lat = kc * (nb - 1) + kc / 2 + 2;
`ifdef RX_SYNC_EN
        lat = lat + 2;
`endif
        ex.d    = e ? d : {1'b0, d[6:0]};
        ex.perr = p & pflip;
        ex.ferr = ~stopv;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < nb * kc; cyc++) begin
            RX_in = bits[cyc / kc];
            wait_clks(1);
            if (cyc + 1 == lat - 1) begin
                check("rdy_before_done", int'(RXRDY), int'(m_rdy));
                CLR_RDY = clr_dn;
            end
            if (cyc + 1 == lat) begin
                CLR_RDY = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_empty", 0, 1);
                end else begin
                    got = sb.pop_front();
                    m_ovf  = clr_dn ? 1'b0 : (m_ovf | m_rdy);
                    m_rdy  = 1'b1;
                    m_data = got.d;
                    m_perr = got.perr;
                    m_ferr = got.ferr;
                    check_outputs("frame");
                end
            end
        end
        RX_in = 1'b1;
        wait_clks(kc);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1; RX_in = 1'b1; CLR_RDY = 1'b0;
        EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0; K = 20'(kc);
        m_rdy = 0; m_ovf = 0; m_perr = 0; m_ferr = 0; m_data = 8'h00;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        check_outputs("reset");

        send_frame(8'h55, 1, 1, 0, 0, 1, 0);
        clear_rdy();
        send_frame(8'h55, 1, 1, 0, 1, 1, 0);
        clear_rdy();
        send_frame(8'h55, 1, 1, 0, 0, 0, 0);
        clear_rdy();
        send_frame(8'h7F, 0, 0, 0, 0, 1, 0);
        clear_rdy();

        // Short low glitch must be rejected as a false start
        RX_in = 1'b0;
        wait_clks(4);
        RX_in = 1'b1;
        wait_clks(3 * kc);
        check_outputs("glitch");

        send_frame(8'h12, 1, 1, 0, 0, 1, 0);
        send_frame(8'h34, 1, 1, 0, 0, 1, 0);
        check("ovf_set", int'(OVF), 1);
        clear_rdy();
        send_frame(8'h12, 1, 1, 0, 0, 1, 0);
        send_frame(8'h34, 1, 1, 0, 0, 1, 0);
        send_frame(8'h56, 1, 1, 0, 0, 1, 1);
        check("clr_at_done_ovf", int'(OVF), 0);

        // Abort a frame with reset during data bit 4
        v = 8'h3C;
        RX_in = 1'b0;
        wait_clks(kc);
        for (int i = 0; i < 4; i++) begin
            RX_in = v[i];
            wait_clks(kc);
        end
        RX_in = v[4];
        wait_clks(kc / 2);
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        RX_in = 1'b1;
        m_rdy = 0; m_ovf = 0; m_perr = 0; m_ferr = 0; m_data = 8'h00;
        wait_clks(kc);
        check_outputs("midreset");
        send_frame(8'hA5, 1, 1, 0, 0, 1, 0);

        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 32; j++) begin
                v = 8'($urandom);
                send_frame(v, c[2], c[1], c[0], 0, 1, 1);
            end
        end
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
